// File: rtl/contador_bcd_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Presets above 9 would leak non-BCD codes into the segment decoders.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector; prev resets high so a level held through reset is not an edge.
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic borda
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= d;
  end

  assign borda = d & ~prev;

endmodule

// File: rtl/contador_bcd.sv
// Two-digit BCD countdown (99..00) with prescaler and start/pause/load control.
module contador_bcd
  import contador_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       running,
  output logic       done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        st, st_n;
  logic [PW-1:0] presc, presc_n;
  logic [3:0]    tens_n, units_n;
  logic [3:0]    dec_t, dec_u;
  logic [3:0]    ld_t, ld_u;
  logic          done_n;
  logic          start_e, pause_e;
  logic          is_zero, dec_zero;

  detector_borda u_det_start (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (start),
    .borda (start_e)
  );

  detector_borda u_det_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pause),
    .borda (pause_e)
  );

  assign ld_t    = bcd_clamp(load_tens);
  assign ld_u    = bcd_clamp(load_units);
  assign is_zero = (tens == 4'd0) && (units == 4'd0);

  always_comb begin
    dec_t = tens;
    dec_u = units;
    if (units != 4'd0) begin
      dec_u = units - 4'd1;
    end else if (tens != 4'd0) begin
      dec_u = BCD_MAX;
      dec_t = tens - 4'd1;
    end
  end

  assign dec_zero = (dec_t == 4'd0) && (dec_u == 4'd0);

  always_comb begin
    st_n    = st;
    tens_n  = tens;
    units_n = units;
    presc_n = presc;
    done_n  = 1'b0;
    case (st)
      IDLE: begin
        if (load) begin
          tens_n  = ld_t;
          units_n = ld_u;
          presc_n = '0;
        end else if (pause_e) begin
          st_n = IDLE;
        end else if (start_e) begin
          if (is_zero) begin
            st_n   = DONE;
            done_n = 1'b1;
          end else begin
            st_n = RUN;
          end
        end
      end
      RUN: begin
        // Pause wins over counting: the paused cycle does not advance the prescaler.
        if (pause_e) begin
          st_n = PAUSED;
        end else if (presc == PRESC_LAST) begin
          presc_n = '0;
          if (!is_zero) begin
            tens_n  = dec_t;
            units_n = dec_u;
          end
          if (dec_zero) begin
            st_n   = DONE;
            done_n = 1'b1;
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      PAUSED: begin
        if (load) begin
          st_n    = IDLE;
          tens_n  = ld_t;
          units_n = ld_u;
          presc_n = '0;
        end else if (pause_e) begin
          st_n = PAUSED;
        end else if (start_e) begin
          st_n = RUN;
        end
      end
      DONE: begin
        if (load) begin
          st_n    = IDLE;
          tens_n  = ld_t;
          units_n = ld_u;
          presc_n = '0;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= IDLE;
      presc   <= '0;
      tens    <= 4'd0;
      units   <= 4'd0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      st      <= st_n;
      presc   <= presc_n;
      tens    <= tens_n;
      units   <= units_n;
      running <= (st_n == RUN);
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_contador_bcd.sv
// Directed bench for contador_bcd with TICK_DIV=4 and hand-computed expectations.
module tb_contador_bcd;
  import contador_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_units;
  logic       start;
  logic       pause;
  logic [3:0] tens;
  logic [3:0] units;
  logic       running;
  logic       done;

  int errs   = 0;
  int checks = 0;

  contador_bcd #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_tens  (load_tens),
    .load_units (load_units),
    .start      (start),
    .pause      (pause),
    .tens       (tens),
    .units      (units),
    .running    (running),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic val(input string tag, input logic [3:0] t, input logic [3:0] u);
    chk(tag, {tens, units}, {t, u});
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] u);
    load = 1'b1; load_tens = t; load_units = u;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; load_tens = 4'd0; load_units = 4'd0;
    start = 1'b1; pause = 1'b1;
    cyc(2);
    // reset state with buttons held
    val("rst_val", 4'd0, 4'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    cyc(2);
    chk("held_no_edge_st", 32'(dut.st), 32'(IDLE));
    chk("held_no_edge_run", 32'(running), 32'd0);
    start = 1'b0; pause = 1'b0;
    cyc(2);
    chk("release_st", 32'(dut.st), 32'(IDLE));

    // load 1,2 and count to 00
    do_load(4'd1, 4'd2);
    val("load12", 4'd1, 4'd2);
    pulse_start();
    chk("run_rise", 32'(running), 32'd1);
    cyc(3);
    val("pre_first_dec", 4'd1, 4'd2);
    cyc(1);
    val("c4", 4'd1, 4'd1);
    cyc(4);
    val("c8", 4'd1, 4'd0);
    cyc(4);
    val("c12_borrow", 4'd0, 4'd9);
    cyc(35);
    val("c47", 4'd0, 4'd1);
    chk("c47_done", 32'(done), 32'd0);
    cyc(1);
    val("c48", 4'd0, 4'd0);
    chk("c48_done", 32'(done), 32'd1);
    chk("c48_running", 32'(running), 32'd0);
    chk("c48_st", 32'(dut.st), 32'(DONE));
    cyc(1);
    chk("c49_done", 32'(done), 32'd0);
    val("c49_hold", 4'd0, 4'd0);
    pulse_start();
    cyc(1);
    chk("done_ignores_start", 32'(dut.st), 32'(DONE));
    chk("done_no_repulse", 32'(done), 32'd0);

    // load 0,5, pause after 5 RUN cycles, resume
    do_load(4'd0, 4'd5);
    chk("load_from_done_st", 32'(dut.st), 32'(IDLE));
    pulse_start();
    cyc(4);
    val("p_c4", 4'd0, 4'd4);
    cyc(1);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    chk("pause_st", 32'(dut.st), 32'(PAUSED));
    chk("pause_running", 32'(running), 32'd0);
    cyc(20);
    val("pause_hold", 4'd0, 4'd4);
    chk("pause_presc", 32'(dut.presc), 32'd1);
    pulse_start();
    chk("resume_running", 32'(running), 32'd1);
    cyc(2);
    val("resume_r2", 4'd0, 4'd4);
    cyc(1);
    val("resume_r3", 4'd0, 4'd3);

    // load during RUN is ignored
    do_load(4'd7, 4'd7);
    val("run_load_ignored", 4'd0, 4'd3);
    chk("run_load_running", 32'(running), 32'd1);
    cyc(2);
    val("run_load_r3", 4'd0, 4'd3);
    cyc(1);
    val("run_load_r4", 4'd0, 4'd2);

    // start+pause together
    start = 1'b1; pause = 1'b1;
    cyc(1);
    start = 1'b0; pause = 1'b0;
    chk("both_run_st", 32'(dut.st), 32'(PAUSED));
    cyc(1);
    start = 1'b1; pause = 1'b1;
    cyc(1);
    start = 1'b0; pause = 1'b0;
    chk("both_paused_st", 32'(dut.st), 32'(PAUSED));

    // clamp
    do_load(4'd15, 4'd12);
    val("clamp", 4'd9, 4'd9);
    chk("clamp_st", 32'(dut.st), 32'(IDLE));
    start = 1'b1; pause = 1'b1;
    cyc(1);
    start = 1'b0; pause = 1'b0;
    chk("both_idle_st", 32'(dut.st), 32'(IDLE));

    // start at 00
    do_load(4'd0, 4'd0);
    cyc(1);
    pulse_start();
    chk("zero_st", 32'(dut.st), 32'(DONE));
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_running", 32'(running), 32'd0);
    cyc(1);
    chk("zero_done_end", 32'(done), 32'd0);

    // reset mid-count
    do_load(4'd3, 4'd8);
    pulse_start();
    cyc(4);
    val("mid_37", 4'd3, 4'd7);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    val("mid_rst_val", 4'd0, 4'd0);
    chk("mid_rst_st", 32'(dut.st), 32'(IDLE));
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_running", 32'(running), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
